// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 Set-2 byte constants, decoder state encoding and event packing.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT       = 8'hE0;
   localparam logic [7:0] PS2_BRK       = 8'hF0;
   localparam logic [7:0] PS2_PAUSE     = 8'hE1;
   localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
   localparam logic [7:0] PS2_ERR0      = 8'h00;
   localparam logic [7:0] PS2_ERR1      = 8'hFF;
   localparam logic [7:0] PS2_BAT_FAIL0 = 8'hFC;
   localparam logic [7:0] PS2_BAT_FAIL1 = 8'hFD;

   localparam int PS2_PAUSE_LEN = 8;
   localparam int PS2_PAUSE_CW  = $clog2(PS2_PAUSE_LEN);
   localparam int PS2_EVT_W     = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } ps2_event_t;

   // Overrun (00/FF) and BAT failure (FC/FD) bytes are reported, never queued.
   function automatic logic is_kb_err(input logic [7:0] b);
      return (b == PS2_ERR0) || (b == PS2_ERR1) ||
             (b == PS2_BAT_FAIL0) || (b == PS2_BAT_FAIL1);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous event FIFO; push on full is accepted only with a same-cycle pop.
module ps2_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   // Head is forced to zero when empty so outputs are defined after reset.
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - folds Set-2 E0/F0/E1 prefixes into key events queued in a FIFO.
// Optional typematic repeat filter: PS2_DEC_TYPEMATIC_FILTER_EN.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] code_in,
   input  logic       code_valid,
   input  logic       ev_ready,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_release,
   input  logic       ovf_clr,
   output logic       overflow,
   output logic       kb_err
);

   ps2_state_t              r_state;
   logic [PS2_PAUSE_CW-1:0] r_pause_cnt;
   logic                    r_overflow;
   logic                    r_kb_err;

   ps2_state_t              w_state_nxt;
   logic [PS2_PAUSE_CW-1:0] w_pause_nxt;
   logic                    w_push_req;
   logic                    w_err;
   ps2_event_t              w_evt;
   logic                    w_suppress;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [PS2_EVT_W-1:0]    w_head;

   always_comb begin
      w_state_nxt = r_state;
      w_pause_nxt = r_pause_cnt;
      w_push_req  = 1'b0;
      w_err       = 1'b0;
      w_evt.ext   = 1'b0;
      w_evt.rel   = 1'b0;
      w_evt.code  = code_in;
      if (code_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (code_in == PS2_EXT) begin
                  w_state_nxt = ST_EXT;
               end else if (code_in == PS2_BRK) begin
                  w_state_nxt = ST_BRK;
               end else if (code_in == PS2_PAUSE) begin
                  w_push_req  = 1'b1;
                  w_pause_nxt = PS2_PAUSE_CW'(PS2_PAUSE_LEN - 1);
                  w_state_nxt = ST_PAUSE;
               end else if (is_kb_err(code_in)) begin
                  w_err = 1'b1;
               end else if (code_in != PS2_BAT_OK) begin
                  w_push_req = 1'b1;
               end
            end
            ST_EXT: begin
               if (code_in == PS2_BRK) begin
                  w_state_nxt = ST_EXT_BRK;
               end else if (code_in != PS2_EXT) begin
                  w_push_req  = 1'b1;
                  w_evt.ext   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               if (code_in != PS2_EXT && code_in != PS2_BRK) begin
                  w_push_req  = 1'b1;
                  w_evt.ext   = (r_state == ST_EXT_BRK);
                  w_evt.rel   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_PAUSE: begin
               // Remaining pause bytes are swallowed regardless of value.
               w_pause_nxt = r_pause_cnt - 1'b1;
               if (r_pause_cnt == PS2_PAUSE_CW'(1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
   logic       r_tm_valid;
   logic [8:0] r_tm_key;
   logic       w_tm_match;

   assign w_tm_match = r_tm_valid && (r_tm_key == {w_evt.ext, w_evt.code});
   assign w_suppress = w_push_req && !w_evt.rel && w_tm_match;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tm_valid <= 1'b0;
         r_tm_key   <= '0;
      end else if (w_push_req) begin
         if (!w_evt.rel && !w_tm_match) begin
            r_tm_valid <= 1'b1;
            r_tm_key   <= {w_evt.ext, w_evt.code};
         end else if (w_evt.rel && w_tm_match) begin
            r_tm_valid <= 1'b0;
         end
      end
   end
`else
   assign w_suppress = 1'b0;
`endif

   assign w_push = w_push_req && !w_suppress;
   assign w_pop  = ev_valid && ev_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_pause_cnt <= '0;
         r_overflow  <= 1'b0;
         r_kb_err    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pause_cnt <= w_pause_nxt;
         // Clear takes priority over a same-cycle set.
         if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_kb_err   <= 1'b0;
         end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_err) r_kb_err <= 1'b1;
         end
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_EVT_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  ({w_evt.ext, w_evt.rel, w_evt.code}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign ev_valid   = !w_empty;
   assign ev_ext     = w_head[9];
   assign ev_release = w_head[8];
   assign ev_code    = w_head[7:0];
   assign overflow   = r_overflow;
   assign kb_err     = r_kb_err;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - directed and random bytes against a prefix-flag reference model.
module tb_ps2_scancode_decoder;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] code_in;
   logic       code_valid;
   logic       ev_ready;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic       ovf_clr;
   logic       overflow;
   logic       kb_err;

   always #5 clk = ~clk;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .ev_ready   (ev_ready),
      .ev_valid   (ev_valid),
      .ev_code    (ev_code),
      .ev_ext     (ev_ext),
      .ev_release (ev_release),
      .ovf_clr    (ovf_clr),
      .overflow   (overflow),
      .kb_err     (kb_err)
   );

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ev_t;

   int         n_cmp  = 0;
   int         n_fail = 0;
   ev_t        q[$];
   logic [7:0] bseq[$];
   bit         m_ext, m_brk, m_ovf, m_err, m_tm_valid, rnd_ready;
   int         m_pause;
   logic [8:0] m_tm_key;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_push(input logic [7:0] c, input bit e, input bit r);
      ev_t ev;
      ev.code = c; ev.ext = e; ev.rel = r;
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
      if (!r) begin
         if (m_tm_valid && m_tm_key == {e, c}) return;
         m_tm_valid = 1'b1;
         m_tm_key   = {e, c};
      end else if (m_tm_valid && m_tm_key == {e, c}) begin
         m_tm_valid = 1'b0;
      end
`endif
      if (q.size() >= DEPTH) m_ovf = 1'b1;
      else q.push_back(ev);
   endfunction

   function automatic void m_byte(input logic [7:0] b);
      if (m_pause > 0) begin
         m_pause--;
      end else if (b == 8'hE0) begin
         if (!m_brk) m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (!m_ext && !m_brk) begin
         if (b == 8'hE1) begin
            m_push(b, 1'b0, 1'b0);
            m_pause = 7;
         end else if (b == 8'h00 || b == 8'hFF || b == 8'hFC || b == 8'hFD) begin
            m_err = 1'b1;
         end else if (b != 8'hAA) begin
            m_push(b, 1'b0, 1'b0);
         end
      end else begin
         m_push(b, m_ext, m_brk);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   task automatic step(input bit v, input logic [7:0] b, input bit clr);
      if (rnd_ready) ev_ready = 1'($urandom_range(0, 1));
      chk("ev_valid", ev_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("ev_code", ev_code, q[0].code);
         chk("ev_ext", ev_ext, q[0].ext);
         chk("ev_release", ev_release, q[0].rel);
      end
      chk("overflow", overflow, m_ovf);
      chk("kb_err", kb_err, m_err);
      if (q.size() != 0 && ev_ready) void'(q.pop_front());
      if (v) m_byte(b);
      if (clr) begin
         m_ovf = 1'b0;
         m_err = 1'b0;
      end
      code_in    = v ? b : 8'($urandom);
      code_valid = v;
      ovf_clr    = clr;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      ovf_clr    = 1'b0;
   endtask

   task automatic send_seq();
      foreach (bseq[i]) step(1'b1, bseq[i], 1'b0);
   endtask

   task automatic drain();
      rnd_ready = 1'b0;
      ev_ready  = 1'b1;
      for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      ev_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      code_valid = 1'b0;
      ovf_clr    = 1'b0;
      ev_ready   = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_tm_valid = 0; m_pause = 0; m_tm_key = '0;
   endtask

   logic [7:0] tbl [16];

   initial begin
      tbl = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFF, 8'hFC, 8'h1C,
              8'h1C, 8'h75, 8'h14, 8'h77, 8'h15, 8'hF0, 8'hE0, 8'h5A};
      rnd_ready = 1'b0;
      code_in   = 8'h00;
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ev_valid", ev_valid, 1'b0);
      chk("rst_ev_code", ev_code, 8'h00);
      chk("rst_ev_ext", ev_ext, 1'b0);
      chk("rst_ev_release", ev_release, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_kb_err", kb_err, 1'b0);

      step(1'b1, 8'h1C, 1'b0);
      chk("latency_make", ev_valid, 1'b1);
      drain();
      bseq = {8'hF0, 8'h1C};
      send_seq();
      chk("latency_break", ev_valid, 1'b1);
      drain();

      bseq = {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
      send_seq();
      drain();

      bseq = {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
      send_seq();
      drain();

      bseq = {8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
      send_seq();
      step(1'b0, 8'h00, 1'b0);
      chk("ovf_set", overflow, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("ovf_cleared", overflow, 1'b0);
      step(1'b1, 8'h2C, 1'b1);
      chk("ovf_clr_wins", overflow, 1'b0);
      ev_ready = 1'b1;
      step(1'b1, 8'h2D, 1'b0);
      drain();

      ev_ready = 1'b1;
      bseq = {8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
      send_seq();
      drain();

      step(1'b1, 8'hE0, 1'b0);
      do_reset();
      step(1'b1, 8'h1C, 1'b0);
      drain();
      step(1'b1, 8'hFF, 1'b0);
      chk("kb_err_set", kb_err, 1'b1);
      chk("kb_err_no_event", ev_valid, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("kb_err_cleared", kb_err, 1'b0);

      do_reset();
      rnd_ready = 1'b1;
      for (int i = 0; i < 800; i++) begin
         logic [7:0] b;
         b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 15)];
         step($urandom_range(0, 3) != 0, b, $urandom_range(0, 60) == 0);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
